// File: rtl/ecp5pll_phase_seq.sv
// ecp5pll_phase_seq
// Dynamic phase-shift sequencer for an ECP5 PLL wrapper built with dynamic_en=1.
// A request moves one PLL output channel by N fine phase steps in one direction.
// The sequencer turns each request into timed phasesel/phasedir/phasestep activity,
// keeps a signed (wrapping) position per channel, and confirms PLL lock afterwards.
//
// Ports
//   clk_i, reset_n           clock, asynchronous active-low reset
//   req_valid/req_ready      request handshake (no queueing, held off while busy)
//   req_chan/dir/steps/clear request fields
//   pll_locked               asynchronous lock from the wrapper (2-FF synchronised)
//   phasesel/phasedir        channel/direction to the wrapper, stable around every pulse
//   phasestep, phaseloadreg  step pulse; loadreg is reserved and tied low
//   busy, done, err,err_code status; done/err are one-cycle pulses
//   pos_flat                 per-channel positions, channel c at [c*POS_W +: POS_W]
module ecp5pll_phase_seq #(
  parameter int CHANNELS    = 4,
  parameter int STEP_W      = 8,
  parameter int POS_W       = 10,
  parameter int SETUP_CYC   = 2,
  parameter int PULSE_CYC   = 4,
  parameter int GAP_CYC     = 4,
  parameter int SETTLE_CYC  = 64,
  parameter int LOCK_TO_CYC = 4096
) (
  input  logic                 clk_i,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_chan,
  input  logic                 req_dir,
  input  logic [STEP_W-1:0]    req_steps,
  input  logic                 req_clear,
  input  logic                 pll_locked,
  output logic [1:0]           phasesel,
  output logic                 phasedir,
  output logic                 phasestep,
  output logic                 phaseloadreg,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [1:0]           err_code,
  output logic [4*POS_W-1:0]   pos_flat
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STEP_HI, S_STEP_LO, S_SETTLE
  } state_t;

  localparam logic [31:0]       SETUP_LAST  = 32'(SETUP_CYC - 1);
  localparam logic [31:0]       PULSE_LAST  = 32'(PULSE_CYC - 1);
  localparam logic [31:0]       GAP_LAST    = 32'(GAP_CYC - 1);
  localparam logic [31:0]       SETTLE_LAST = 32'(SETTLE_CYC - 1);
  localparam logic [31:0]       TO_LAST     = 32'(SETTLE_CYC + LOCK_TO_CYC - 1);
  localparam logic [POS_W-1:0]  POS_ONE     = POS_W'(1);
  localparam logic [STEP_W-1:0] STEP_ONE    = STEP_W'(1);

  state_t            state_q;
  logic              lock_meta_q, lock_sync_q, lock_prev_q;
  logic [31:0]       cnt_q;
  logic [STEP_W-1:0] remain_q;
  logic [1:0]        chan_q;
  logic              dir_q;
  logic              req_ready_q, busy_q, done_q, err_q;
  logic [1:0]        err_code_q;
  logic [1:0]        phasesel_q;
  logic              phasedir_q, phasestep_q;
  // Always four entries so a 2-bit channel index never leaves the array; entries
  // at or above CHANNELS are never written away from zero.
  logic [POS_W-1:0]  pos_q [4];

  logic lock_fall;
  logic accept;

  assign lock_fall = lock_prev_q & ~lock_sync_q;
  assign accept    = (state_q == S_IDLE) & req_valid & req_ready_q;

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
      lock_prev_q <= 1'b0;
      cnt_q       <= '0;
      remain_q    <= '0;
      chan_q      <= '0;
      dir_q       <= 1'b0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= '0;
      phasesel_q  <= '0;
      phasedir_q  <= 1'b0;
      phasestep_q <= 1'b0;
      for (int i = 0; i < 4; i++) pos_q[i] <= '0;
    end else begin
      lock_meta_q <= pll_locked;
      lock_sync_q <= lock_meta_q;
      lock_prev_q <= lock_sync_q;
      done_q      <= 1'b0;
      err_q       <= 1'b0;

      if (state_q != S_IDLE && lock_fall) begin
        // Lock lost: abandon the request at once; steps already completed stay counted.
        state_q     <= S_IDLE;
        phasestep_q <= 1'b0;
        busy_q      <= 1'b0;
        err_q       <= 1'b1;
        err_code_q  <= 2'd2;
        cnt_q       <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            // After a done/err cycle ready_q is still low, so it rises one cycle later.
            req_ready_q <= 1'b1;
            if (accept) begin
              req_ready_q <= 1'b0;
              chan_q      <= req_chan;
              dir_q       <= req_dir;
              remain_q    <= req_steps;
              cnt_q       <= '0;
              if (int'(req_chan) >= CHANNELS) begin
                err_q      <= 1'b1;
                err_code_q <= 2'd1;
              end else if (req_clear) begin
                pos_q[req_chan] <= '0;
                done_q          <= 1'b1;
              end else if (req_steps == '0) begin
                busy_q  <= 1'b1;
                state_q <= S_SETTLE;
              end else begin
                busy_q     <= 1'b1;
                phasesel_q <= req_chan;
                phasedir_q <= req_dir;
                state_q    <= S_SETUP;
              end
            end
          end
          S_SETUP: begin
            if (cnt_q == SETUP_LAST) begin
              cnt_q       <= '0;
              phasestep_q <= 1'b1;
              state_q     <= S_STEP_HI;
            end else begin
              cnt_q <= cnt_q + 32'd1;
            end
          end
          S_STEP_HI: begin
            if (cnt_q == PULSE_LAST) begin
              cnt_q         <= '0;
              phasestep_q   <= 1'b0;
              pos_q[chan_q] <= dir_q ? pos_q[chan_q] + POS_ONE : pos_q[chan_q] - POS_ONE;
              state_q       <= S_STEP_LO;
            end else begin
              cnt_q <= cnt_q + 32'd1;
            end
          end
          S_STEP_LO: begin
            if (cnt_q == GAP_LAST) begin
              cnt_q    <= '0;
              remain_q <= remain_q - STEP_ONE;
              state_q  <= (remain_q == STEP_ONE) ? S_SETTLE : S_SETUP;
            end else begin
              cnt_q <= cnt_q + 32'd1;
            end
          end
          S_SETTLE: begin
            // First SETTLE_CYC cycles are a blind wait; lock is only honoured afterwards.
            if (cnt_q >= SETTLE_LAST && lock_sync_q) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              cnt_q   <= '0;
            end else if (cnt_q == TO_LAST) begin
              state_q    <= S_IDLE;
              busy_q     <= 1'b0;
              err_q      <= 1'b1;
              err_code_q <= 2'd3;
              cnt_q      <= '0;
            end else begin
              cnt_q <= cnt_q + 32'd1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign req_ready    = req_ready_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign err_code     = err_code_q;
  assign phasesel     = phasesel_q;
  assign phasedir     = phasedir_q;
  assign phasestep    = phasestep_q;
  assign phaseloadreg = 1'b0;

  for (genvar gi = 0; gi < 4; gi++) begin : g_pos
    if (gi < CHANNELS) begin : g_used
      assign pos_flat[gi*POS_W +: POS_W] = pos_q[gi];
    end else begin : g_unused
      assign pos_flat[gi*POS_W +: POS_W] = '0;
    end
  end

endmodule

// File: tb/tb_ecp5pll_phase_seq.sv
// Bench for ecp5pll_phase_seq: a table of directed requests, randomized requests checked
// against a position/latency model, and hand-written lock-loss, timeout, bad-channel and
// asynchronous-reset sequences.
module tb_ecp5pll_phase_seq;
  localparam int POS_W = 10, STEP_W = 8;
  localparam int S = 64, L = 4096, SETUP = 2, PULSE = 4, GAP = 4;
  localparam int STEP_PERIOD = SETUP + PULSE + GAP;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic req_valid = 0, req_dir = 0, req_clear = 0, pll_locked = 1;
  logic [1:0] req_chan = 0;
  logic [STEP_W-1:0] req_steps = 0;
  logic req_ready, phasedir, phasestep, phaseloadreg, busy, done, err;
  logic [1:0] phasesel, err_code;
  logic [4*POS_W-1:0] pos_flat;

  logic req2_valid = 0, req2_dir = 0, req2_clear = 0, pll_locked2 = 1;
  logic [1:0] req2_chan = 0;
  logic [STEP_W-1:0] req2_steps = 0;
  logic req2_ready, phasedir2, phasestep2, phaseloadreg2, busy2, done2, err2;
  logic [1:0] phasesel2, err_code2;
  logic [4*POS_W-1:0] pos_flat2;

  ecp5pll_phase_seq u_dut (
    .clk_i(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_chan(req_chan), .req_dir(req_dir), .req_steps(req_steps), .req_clear(req_clear),
    .pll_locked(pll_locked), .phasesel(phasesel), .phasedir(phasedir), .phasestep(phasestep),
    .phaseloadreg(phaseloadreg), .busy(busy), .done(done), .err(err), .err_code(err_code),
    .pos_flat(pos_flat));

  ecp5pll_phase_seq #(.CHANNELS(2), .SETTLE_CYC(8), .LOCK_TO_CYC(64)) u_dut2 (
    .clk_i(clk), .reset_n(reset_n), .req_valid(req2_valid), .req_ready(req2_ready),
    .req_chan(req2_chan), .req_dir(req2_dir), .req_steps(req2_steps), .req_clear(req2_clear),
    .pll_locked(pll_locked2), .phasesel(phasesel2), .phasedir(phasedir2), .phasestep(phasestep2),
    .phaseloadreg(phaseloadreg2), .busy(busy2), .done(done2), .err(err2), .err_code(err_code2),
    .pos_flat(pos_flat2));

  int checks = 0, errors = 0;
  int model_pos [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [4*POS_W-1:0] model_flat();
    logic [4*POS_W-1:0] r;
    for (int i = 0; i < 4; i++) r[i*POS_W +: POS_W] = POS_W'(model_pos[i]);
    return r;
  endfunction

  // Pulse-shape monitor, sampled on the falling edge.
  int mon_pulses = 0, mon_hi_bad = 0, mon_lo_bad = 0, mon_sel_bad = 0;
  int hi_run = 0, lo_run = 0, sel_stable = 0;
  logic ps_prev = 0, busy_prev = 0;
  logic [2:0] sd_prev = 0;
  always @(negedge clk) begin
    if (!reset_n) begin
      hi_run = 0; lo_run = 0; ps_prev = 0; sel_stable = 0; busy_prev = 0;
    end else begin
      if ({phasesel, phasedir} == sd_prev) sel_stable++;
      else begin
        if (busy && busy_prev) mon_sel_bad++;
        sel_stable = 0;
      end
      sd_prev = {phasesel, phasedir};
      if (phasestep && !ps_prev) begin
        mon_pulses++;
        if (sel_stable < SETUP) mon_sel_bad++;
        // Between pulses of one request the line is low for STEP_LO plus the next SETUP.
        if (lo_run != 0 && lo_run != GAP + SETUP) mon_lo_bad++;
        hi_run = 1; lo_run = 0;
      end else if (phasestep) hi_run++;
      else if (ps_prev) begin
        if (hi_run != PULSE) mon_hi_bad++;
        lo_run = 1;
      end else if (lo_run != 0) lo_run++;
      if (!busy) lo_run = 0;
      ps_prev = phasestep;
      busy_prev = busy;
    end
  end

  // One request on the main DUT; exp_code 0 means a done pulse is expected.
  task automatic do_req(input logic [1:0] ch, input logic d, input int n, input logic clr,
                        input int exp_code, input string tag);
    int p0, bad0, lat, exp_lat, exp_pulses, k;
    k = 0;
    while (!req_ready && k < 200) begin @(posedge clk); #1; k++; end
    chk({tag, "_ready_in"}, 64'(req_ready), 64'(1));
    p0 = mon_pulses; bad0 = mon_hi_bad + mon_lo_bad + mon_sel_bad;
    req_chan = ch; req_dir = d; req_steps = STEP_W'(n); req_clear = clr; req_valid = 1;
    @(posedge clk); #1;
    req_valid = 0;
    if (clr) begin
      model_pos[ch] = 0; exp_lat = 0; exp_pulses = 0;
    end else begin
      model_pos[ch] = (model_pos[ch] + (d ? n : -n)) & ((1 << POS_W) - 1);
      exp_pulses = n;
      exp_lat = n * STEP_PERIOD + S + ((exp_code == 3) ? L : 0);
    end
    lat = 0;
    while (!(done || err) && lat < exp_lat + 20) begin @(posedge clk); #1; lat++; end
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_done"}, 64'(done), 64'(exp_code == 0));
    chk({tag, "_err"}, 64'(err), 64'(exp_code != 0));
    if (exp_code != 0) chk({tag, "_err_code"}, 64'(err_code), 64'(exp_code));
    chk({tag, "_busy_at_end"}, 64'(busy), 64'(0));
    chk({tag, "_pulses"}, 64'(mon_pulses - p0), 64'(exp_pulses));
    chk({tag, "_pulse_shape"}, 64'(mon_hi_bad + mon_lo_bad + mon_sel_bad - bad0), 64'(0));
    chk({tag, "_pos"}, 64'(pos_flat), 64'(model_flat()));
    chk({tag, "_ready_low_at_end"}, 64'(req_ready), 64'(0));
    @(posedge clk); #1;
    chk({tag, "_ready_after"}, 64'(req_ready), 64'(1));
    chk({tag, "_pulse_once"}, 64'(done | err), 64'(0));
    $display("txn %s ch=%0d dir=%0d steps=%0d clear=%0d latency=%0d pos=0x%0h", tag, ch, d, n,
             clr, lat, pos_flat);
  endtask

  typedef struct {
    logic [1:0]       ch;
    logic             dir;
    int               steps;
    logic             clr;
    logic [POS_W-1:0] exp_pos;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int p0, lat, k;
    logic [4*POS_W-1:0] e2;
    for (int i = 0; i < 4; i++) model_pos[i] = 0;
    tbl[0] = '{2'd1, 1'b1, 3, 1'b0, 10'd3};
    tbl[1] = '{2'd2, 1'b0, 5, 1'b0, 10'h3FB};
    tbl[2] = '{2'd2, 1'b0, 0, 1'b1, 10'd0};
    tbl[3] = '{2'd0, 1'b1, 0, 1'b0, 10'd0};
    tbl[4] = '{2'd3, 1'b1, 1, 1'b0, 10'd1};
    tbl[5] = '{2'd3, 1'b0, 2, 1'b0, 10'h3FF};

    reset_n = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(req_ready), 64'(1));
    chk("rst_flags", 64'({busy, done, err, phasestep, phaseloadreg, phasedir}), 64'(0));
    chk("rst_sel_code", 64'({phasesel, err_code}), 64'(0));
    chk("rst_pos", 64'(pos_flat), 64'(0));
    @(negedge clk); reset_n = 1;
    repeat (5) @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      do_req(tbl[i].ch, tbl[i].dir, tbl[i].steps, tbl[i].clr, 0, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d_table_pos", i), 64'(pos_flat[tbl[i].ch*POS_W +: POS_W]),
          64'(tbl[i].exp_pos));
    end

    for (int i = 0; i < 12; i++)
      do_req(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom_range(0, 20),
             ($urandom_range(0, 7) == 0), 0, $sformatf("rnd%0d", i));
    do_req(2'd0, 1'b0, 255, 1'b0, 0, "max_steps");

    // Lock lost after pulse 50 of a 200-step request.
    p0 = mon_pulses; k = 0;
    req_chan = 2'd3; req_dir = 1; req_steps = 8'd200; req_clear = 0; req_valid = 1;
    @(posedge clk); #1; req_valid = 0;
    while (!((mon_pulses - p0) == 50 && !phasestep) && k < 1000) begin @(negedge clk); k++; end
    pll_locked = 0;
    lat = 0;
    while (!err && lat < 10) begin @(posedge clk); #1; lat++; end
    model_pos[3] = (model_pos[3] + 50) & ((1 << POS_W) - 1);
    chk("loss50_latency", 64'(lat), 64'(3));
    chk("loss50_code", 64'(err_code), 64'(2));
    chk("loss50_step_low", 64'(phasestep), 64'(0));
    chk("loss50_pos", 64'(pos_flat), 64'(model_flat()));
    chk("loss50_busy", 64'(busy), 64'(0));
    @(posedge clk); #1;
    chk("loss50_ready", 64'(req_ready), 64'(1));
    repeat (5) @(posedge clk);
    chk("loss50_pulses", 64'(mon_pulses - p0), 64'(50));
    $display("txn lock_loss_after_50 latency=%0d pos=0x%0h", lat, pos_flat);
    pll_locked = 1;
    repeat (5) @(posedge clk);
    #1;

    // Lock lost in the middle of the first high pulse: the pulse is cut, not counted.
    k = 0;
    req_chan = 2'd0; req_dir = 1; req_steps = 8'd5; req_valid = 1;
    @(posedge clk); #1; req_valid = 0;
    while (!phasestep && k < 50) begin @(negedge clk); k++; end
    pll_locked = 0;
    lat = 0;
    while (!err && lat < 10) begin @(posedge clk); #1; lat++; end
    chk("losshi_latency", 64'(lat), 64'(3));
    chk("losshi_step_low", 64'(phasestep), 64'(0));
    chk("losshi_code", 64'(err_code), 64'(2));
    chk("losshi_pos", 64'(pos_flat), 64'(model_flat()));
    $display("txn lock_loss_mid_pulse latency=%0d pos=0x%0h", lat, pos_flat);

    // Lock held low through SETTLE -> timeout.
    repeat (5) @(posedge clk);
    #1;
    do_req(2'd1, 1'b0, 0, 1'b0, 3, "timeout");
    pll_locked = 1;
    repeat (5) @(posedge clk);
    #1;

    // Two-channel instance: move ch1, then reject channels 3 and 2.
    req2_chan = 2'd1; req2_dir = 1; req2_steps = 8'd2; req2_valid = 1;
    @(posedge clk); #1; req2_valid = 0;
    k = 0;
    while (!done2 && k < 100) begin @(posedge clk); #1; k++; end
    chk("two_ch_done_latency", 64'(k), 64'(2 * STEP_PERIOD + 8));
    e2 = '0; e2[POS_W +: POS_W] = 10'd2;
    chk("two_ch_pos", 64'(pos_flat2), 64'(e2));
    for (int c = 3; c >= 2; c--) begin
      repeat (2) @(posedge clk);
      #1;
      req2_chan = 2'(c); req2_valid = 1;
      @(posedge clk); #1; req2_valid = 0;
      chk($sformatf("badch%0d_err", c), 64'({err2, done2, busy2}), 64'(3'b100));
      chk($sformatf("badch%0d_code", c), 64'(err_code2), 64'(1));
      chk($sformatf("badch%0d_ready_low", c), 64'(req2_ready), 64'(0));
      k = 0;
      for (int j = 0; j < 10; j++) begin
        @(posedge clk); #1;
        if (phasestep2 || busy2) k++;
        if (j == 0) chk($sformatf("badch%0d_ready_after", c), 64'(req2_ready), 64'(1));
      end
      chk($sformatf("badch%0d_no_pulses", c), 64'(k), 64'(0));
      chk($sformatf("badch%0d_pos", c), 64'(pos_flat2), 64'(e2));
      $display("txn bad_chan chan=%0d err_code=%0d pos=0x%0h", c, err_code2, pos_flat2);
    end

    // Asynchronous reset while phasestep is high.
    k = 0;
    req_chan = 2'd0; req_dir = 1; req_steps = 8'd10; req_valid = 1;
    @(posedge clk); #1; req_valid = 0;
    while (!phasestep && k < 50) begin @(negedge clk); k++; end
    #2 reset_n = 0;
    #1;
    for (int i = 0; i < 4; i++) model_pos[i] = 0;
    chk("arst_step", 64'(phasestep), 64'(0));
    chk("arst_flags", 64'({busy, done, err, phasedir, phasesel, err_code}), 64'(0));
    chk("arst_ready", 64'(req_ready), 64'(1));
    chk("arst_pos", 64'(pos_flat), 64'(model_flat()));
    $display("txn async_reset_mid_pulse pos=0x%0h", pos_flat);
    @(negedge clk); reset_n = 1;
    repeat (5) @(posedge clk);
    #1;
    do_req(2'd2, 1'b1, 2, 1'b0, 0, "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, %0d errors so far", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
